framebuffer_arbiter: RTL

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

---
 rtl/framebuffer_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/framebuffer_arbiter.sv
// Framebuffer arbiter: scan-out video has absolute priority, two clients share the rest.
// Define FBARB_STATS_EN to enable the video stall counter (stall_cnt).
module framebuffer_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int BW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_END =
    BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE, OWN0, OWN1
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE, SRC_VID, SRC_P0, SRC_P1
  } src_t;

  state_t        state;
  logic          last;
  logic [BW-1:0] burst;
  src_t          tag1;
  src_t          tag2;
  logic          burst_end;
  logic          acc0;
  logic          acc1;
  logic          same_owner;

  assign burst_end = (burst == BURST_END);
  assign acc0      = req0 & gnt0;
  assign acc1      = req1 & gnt1;
  assign same_owner =
    (acc0 && state == OWN0) ||
    (acc1 && state == OWN1);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !vid_req) begin
      case (state)
        OWN0: begin
          if (req0 && !(burst_end && req1))
            gnt0 = 1'b1;
          else if (req1)
            gnt1 = 1'b1;
        end
        OWN1: begin
          if (req1 && !(burst_end && req0))
            gnt1 = 1'b1;
          else if (req0)
            gnt0 = 1'b1;
        end
        default: begin
          if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // Video steals the RAM port without disturbing arbitration state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst     <= '0;
      tag1      <= SRC_NONE;
      tag2      <= SRC_NONE;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      tag2 <= tag1;
      if (vid_req) begin
        mem_we   <= 1'b0;
        mem_re   <= 1'b1;
        mem_addr <= vid_addr;
        tag1     <= SRC_VID;
      end else if (acc0 || acc1) begin
        state <= acc0 ? OWN0 : OWN1;
        last  <= acc1;
        if (!same_owner)
          burst <= '0;
        else if (!burst_end)
          burst <= burst + BW'(1);
        mem_we    <= acc0 ? we0 : we1;
        mem_re    <= acc0 ? ~we0 : ~we1;
        mem_addr  <= acc0 ? addr0 : addr1;
        mem_wdata <= acc0 ? wdata0 : wdata1;
        if (acc0 ? we0 : we1)
          tag1 <= SRC_NONE;
        else
          tag1 <= acc0 ? SRC_P0 : SRC_P1;
      end else begin
        state  <= IDLE;
        burst  <= '0;
        mem_we <= 1'b0;
        mem_re <= 1'b0;
        tag1   <= SRC_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_rvalid <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      vid_rdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      vid_rvalid <= (tag2 == SRC_VID);
      rvalid0    <= (tag2 == SRC_P0);
      rvalid1    <= (tag2 == SRC_P1);
      if (tag2 == SRC_VID)
        vid_rdata <= mem_rdata;
      if (tag2 == SRC_P0)
        rdata0 <= mem_rdata;
      if (tag2 == SRC_P1)
        rdata1 <= mem_rdata;
    end
  end

`ifdef FBARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (vid_req && (req0 || req1) &&
             stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
